// File: rtl/dram_ctrl_pkg.sv
// Shared definitions for the DRAM command scheduler: command encodings, FSM states and
// request-word field layout.
package dram_ctrl_pkg;

  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_ACT = 2'b01;
  localparam logic [1:0] CMD_RW  = 2'b10;
  localparam logic [1:0] CMD_PRE = 2'b11;

  localparam int unsigned BANK_LSB = 19;
  localparam int unsigned BANK_W   = 3;
  localparam int unsigned ROW_LSB  = 12;
  localparam int unsigned ROW_W    = 7;
  localparam int unsigned COL_LSB  = 9;
  localparam int unsigned COL_W    = 3;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StWaitRp,
    StAct,
    StWaitRcd,
    StRw,
    StWaitCl,
    StResp
  } state_e;

endpackage

// File: rtl/dram_cmd_scheduler_if.sv
// Requester-side bundle: request handshake from the L2 buffers and the completion return.
interface dram_cmd_scheduler_if #(
  parameter int unsigned NUM_REQ      = 8,
  parameter int unsigned L2_REQ_WIDTH = 22,
  parameter int unsigned DATA_WIDTH   = 1
);
  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_ready;
  logic [NUM_REQ*L2_REQ_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]              req_rw;
  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata;
  logic [NUM_REQ-1:0]              rsp_valid;
  logic [DATA_WIDTH-1:0]           rsp_data;

  modport master (
    output req_valid, req_addr, req_rw, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, req_rw, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/dram_rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or above ptr_i, wrapping.
module dram_rr_arbiter #(
  parameter int unsigned NUM_REQ = 8,
  localparam int unsigned IdW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdW-1:0]     ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IdW-1:0]     id_o,
  output logic               valid_o
);

  int unsigned        idx;
  logic [IdW-1:0]     sel;

  always_comb begin
    gnt_o   = '0;
    id_o    = '0;
    valid_o = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr_i) + k) % NUM_REQ;
      sel = IdW'(idx);
      if (en_i && !valid_o && req_i[sel]) begin
        valid_o    = 1'b1;
        gnt_o[sel] = 1'b1;
        id_o       = sel;
      end
    end
  end

endmodule

// File: rtl/dram_cmd_scheduler.sv
// Single-outstanding DRAM command scheduler with open-page row tracking per bank and
// round-robin arbitration across the L2 requester ports.
module dram_cmd_scheduler
  import dram_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 8,
  parameter int unsigned L2_REQ_WIDTH = 22,
  parameter int unsigned DATA_WIDTH   = 1,
  parameter int unsigned NUM_OF_BANKS = 8,
  parameter int unsigned NUM_OF_ROWS  = 128,
  parameter int unsigned NUM_OF_COLS  = 8,
  parameter int unsigned T_RP         = 2,
  parameter int unsigned T_RCD        = 2,
  parameter int unsigned T_CL         = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  dram_cmd_scheduler_if.slave     req_if,
  input  logic [DATA_WIDTH-1:0]   dram_data_in,
  output logic [1:0]              cmd,
  output logic [BANK_W-1:0]       cs,
  output logic [ROW_W-1:0]        row_addr,
  output logic [COL_W-1:0]        col_addr,
  output logic                    dram_rw,
  output logic [DATA_WIDTH-1:0]   dram_data_out
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  state_e                              state_q, state_d;
  logic [IdW-1:0]                      rr_ptr_q, rr_ptr_d, id_q, id_d, gnt_id;
  logic [NUM_REQ-1:0]                  gnt;
  logic                                gnt_valid, arb_en;
  logic [BANK_W-1:0]                   bank_q, bank_d, gnt_bank;
  logic [ROW_W-1:0]                    row_q, row_d, gnt_row;
  logic [COL_W-1:0]                    col_q, col_d, gnt_col;
  logic                                rw_q, rw_d, gnt_rw;
  logic [DATA_WIDTH-1:0]               wdata_q, wdata_d, gnt_wdata;
  logic [DATA_WIDTH-1:0]               rdata_q, rdata_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [NUM_OF_BANKS-1:0]             bank_open_q, bank_open_d;
  logic [NUM_OF_BANKS-1:0][ROW_W-1:0]  open_row_q, open_row_d;
  logic [NUM_REQ-1:0]                  rsp_valid;
  logic [DATA_WIDTH-1:0]               rsp_data;
  logic                                unused_params;

  assign unused_params = ^{NUM_OF_ROWS, NUM_OF_COLS};

  assign arb_en = (state_q == StIdle) && !rst;

  dram_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i   (req_if.req_valid),
    .ptr_i   (rr_ptr_q),
    .en_i    (arb_en),
    .gnt_o   (gnt),
    .id_o    (gnt_id),
    .valid_o (gnt_valid)
  );

  assign req_if.req_ready = gnt;
  assign req_if.rsp_valid = rsp_valid;
  assign req_if.rsp_data  = rsp_data;

  // Offset bits of the request word are don't-care and intentionally dropped here.
  always_comb begin
    gnt_bank  = '0;
    gnt_row   = '0;
    gnt_col   = '0;
    gnt_rw    = 1'b0;
    gnt_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == IdW'(i)) begin
        gnt_bank  = req_if.req_addr[i*L2_REQ_WIDTH+BANK_LSB +: BANK_W];
        gnt_row   = req_if.req_addr[i*L2_REQ_WIDTH+ROW_LSB +: ROW_W];
        gnt_col   = req_if.req_addr[i*L2_REQ_WIDTH+COL_LSB +: COL_W];
        gnt_rw    = req_if.req_rw[i];
        gnt_wdata = req_if.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    id_d          = id_q;
    bank_d        = bank_q;
    row_d         = row_q;
    col_d         = col_q;
    rw_d          = rw_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    cnt_d         = cnt_q;
    bank_open_d   = bank_open_q;
    open_row_d    = open_row_q;
    cmd           = CMD_NOP;
    cs            = '0;
    row_addr      = '0;
    col_addr      = '0;
    dram_rw       = 1'b0;
    dram_data_out = '0;
    rsp_valid     = '0;
    rsp_data      = '0;

    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          bank_d   = gnt_bank;
          row_d    = gnt_row;
          col_d    = gnt_col;
          rw_d     = gnt_rw;
          wdata_d  = gnt_wdata;
          id_d     = gnt_id;
          rdata_d  = '0;
          rr_ptr_d = (gnt_id == IdW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
          if (!bank_open_q[gnt_bank])                 state_d = StAct;
          else if (open_row_q[gnt_bank] == gnt_row)   state_d = StRw;
          else                                        state_d = StPre;
        end
      end
      StPre: begin
        cmd                 = CMD_PRE;
        cs                  = bank_q;
        bank_open_d[bank_q] = 1'b0;
        cnt_d               = CNT_W'(T_RP - 1);
        state_d             = (T_RP > 1) ? StWaitRp : StAct;
      end
      StWaitRp: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = StAct;
      end
      StAct: begin
        cmd                 = CMD_ACT;
        cs                  = bank_q;
        row_addr            = row_q;
        bank_open_d[bank_q] = 1'b1;
        open_row_d[bank_q]  = row_q;
        cnt_d               = CNT_W'(T_RCD - 1);
        state_d             = (T_RCD > 1) ? StWaitRcd : StRw;
      end
      StWaitRcd: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = StRw;
      end
      StRw: begin
        cmd      = CMD_RW;
        cs       = bank_q;
        col_addr = col_q;
        dram_rw  = rw_q;
        if (rw_q) begin
          cnt_d   = CNT_W'(T_CL - 1);
          state_d = StWaitCl;
        end else begin
          dram_data_out = wdata_q;
          state_d       = StResp;
        end
      end
      // Stays T_CL cycles so the sample lands exactly T_CL cycles after the RW command.
      StWaitCl: begin
        if (cnt_q == '0) begin
          rdata_d = dram_data_in;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        rsp_valid[id_q] = 1'b1;
        rsp_data        = rdata_q;
        state_d         = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      bank_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      rw_q        <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      bank_open_q <= '0;
      open_row_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      bank_q      <= bank_d;
      row_q       <= row_d;
      col_q       <= col_d;
      rw_q        <= rw_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      bank_open_q <= bank_open_d;
      open_row_q  <= open_row_d;
    end
  end

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Self-checking bench for dram_cmd_scheduler: per-cycle comparison of every output against
// a transaction-level timeline model (open-row table, round-robin pointer, timing offsets).
module tb_dram_cmd_scheduler;

  localparam int unsigned NREQ = 8;
  localparam int unsigned AW   = 22;
  localparam int unsigned DW   = 1;
  localparam int unsigned TRP  = 2;
  localparam int unsigned TRCD = 2;
  localparam int unsigned TCL  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] dram_data_in, dram_data_out;
  logic [1:0]    cmd;
  logic [2:0]    cs, col_addr;
  logic [6:0]    row_addr;
  logic          dram_rw;

  always #5 clk = ~clk;

  dram_cmd_scheduler_if #(.NUM_REQ(NREQ), .L2_REQ_WIDTH(AW), .DATA_WIDTH(DW)) ifc ();

  dram_cmd_scheduler #(
    .NUM_REQ(NREQ), .L2_REQ_WIDTH(AW), .DATA_WIDTH(DW),
    .T_RP(TRP), .T_RCD(TRCD), .T_CL(TCL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_if        (ifc),
    .dram_data_in  (dram_data_in),
    .cmd           (cmd),
    .cs            (cs),
    .row_addr      (row_addr),
    .col_addr      (col_addr),
    .dram_rw       (dram_rw),
    .dram_data_out (dram_data_out)
  );

  // Reference model state
  bit          m_open [8];
  logic [6:0]  m_row  [8];
  int          m_ptr;
  logic [21:0] p_addr [8];
  logic        p_rw   [8];
  logic        p_wdata[8];

  int passed = 0;
  int total  = 0;

  function automatic logic [33:0] observe();
    return {ifc.req_ready, cmd, cs, row_addr, col_addr, dram_rw, dram_data_out,
            ifc.rsp_valid, ifc.rsp_data};
  endfunction

  function automatic logic [21:0] mk_addr(int b, int r, int c);
    logic [8:0] off;
    off = 9'($urandom_range(0, 511));
    return {3'(b), 7'(r), 3'(c), off};
  endfunction

  task automatic load_ports();
    for (int i = 0; i < 8; i++) begin
      ifc.req_addr[i*AW +: AW] = p_addr[i];
      ifc.req_rw[i]            = p_rw[i];
      ifc.req_wdata[i]         = p_wdata[i];
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_open[i] = 1'b0;
      m_row[i]  = '0;
    end
    m_ptr = 0;
  endtask

  // One transaction; abort_c >= 0 asserts reset during that cycle instead of completing.
  task automatic run_txn(input logic [7:0] mask, input int abort_c, input string name);
    int p, pre_c, act_c, rw_c, resp_c;
    logic [2:0] bank, col;
    logic [6:0] row;
    logic       rdbit;
    logic [7:0] oh;
    logic [33:0] exp_v, obs_v;
    load_ports();
    p = -1;
    for (int k = 0; k < 8; k++)
      if (p < 0 && mask[(m_ptr + k) % 8]) p = (m_ptr + k) % 8;
    bank  = p_addr[p][21:19];
    row   = p_addr[p][18:12];
    col   = p_addr[p][11:9];
    oh    = 8'(1 << p);
    pre_c = -1;
    act_c = -1;
    if (m_open[bank] && m_row[bank] == row) begin
      rw_c = 1;
    end else if (m_open[bank]) begin
      pre_c = 1;
      act_c = 1 + TRP;
      rw_c  = act_c + TRCD;
    end else begin
      act_c = 1;
      rw_c  = 1 + TRCD;
    end
    resp_c = p_rw[p] ? rw_c + TCL + 1 : rw_c + 1;
    rdbit  = 1'($urandom_range(0, 1));
    m_ptr  = (p + 1) % 8;
    for (int c = 0; c <= resp_c; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) ifc.req_valid = mask;
      dram_data_in = (c == rw_c + TCL) ? rdbit : ~rdbit;
      if (c == abort_c) rst = 1'b1;
      #1;
      exp_v = {(c == 0) ? oh : 8'h00,
               (c == pre_c) ? 2'b11 : (c == act_c) ? 2'b01 : (c == rw_c) ? 2'b10 : 2'b00,
               (c == pre_c || c == act_c || c == rw_c) ? bank : 3'd0,
               (c == act_c) ? row : 7'd0,
               (c == rw_c) ? col : 3'd0,
               (c == rw_c) ? p_rw[p] : 1'b0,
               (c == rw_c && !p_rw[p]) ? p_wdata[p] : 1'b0,
               (c == resp_c) ? oh : 8'h00,
               (c == resp_c && p_rw[p]) ? rdbit : 1'b0};
      if (c == abort_c) exp_v = '0;
      obs_v = observe();
      total++;
      if (obs_v !== exp_v)
        $display("FAIL %s port%0d cycle %0d: got %h expected %h", name, p, c, obs_v, exp_v);
      else passed++;
      if (c == abort_c) begin
        // Held reset with requests still valid: everything, including ready, must stay 0.
        for (int h = 0; h < 2; h++) begin
          @(posedge clk);
          #2;
          obs_v = observe();
          total++;
          if (obs_v !== '0)
            $display("FAIL %s_held cycle %0d: got %h expected 0", name, h, obs_v);
          else passed++;
        end
        ifc.req_valid = '0;
        rst = 1'b0;
        model_clear();
        return;
      end
    end
    ifc.req_valid = '0;
    m_open[bank] = 1'b1;
    m_row[bank]  = row;
  endtask

  task automatic test_reset();
    logic [33:0] obs_v;
    rst           = 1'b1;
    ifc.req_valid = '1;
    dram_data_in  = '1;
    for (int i = 0; i < 8; i++) begin
      p_addr[i]  = mk_addr(i, i, i);
      p_rw[i]    = 1'b0;
      p_wdata[i] = 1'b1;
    end
    load_ports();
    model_clear();
    repeat (2) @(posedge clk);
    #2;
    obs_v = observe();
    total++;
    if (obs_v !== '0) $display("FAIL reset_outputs: got %h expected 0", obs_v);
    else passed++;
    ifc.req_valid = '0;
    rst = 1'b0;
    @(posedge clk);
    #2;
    obs_v = observe();
    total++;
    if (obs_v !== '0) $display("FAIL idle_no_req: got %h expected 0", obs_v);
    else passed++;
  endtask

  task automatic test_directed();
    p_addr[0] = 22'h185400; p_rw[0] = 1'b1; p_wdata[0] = 1'b0;
    run_txn(8'h01, -1, "closed_read");
    p_addr[2] = 22'h185E00; p_rw[2] = 1'b0; p_wdata[2] = 1'b1;
    run_txn(8'h04, -1, "row_hit_write");
    p_addr[4] = 22'h186000; p_rw[4] = 1'b1; p_wdata[4] = 1'b0;
    run_txn(8'h10, -1, "row_miss_read");
  endtask

  task automatic test_round_robin();
    // Pointer sits at 5 after the port-4 access above.
    p_addr[1] = mk_addr(2, 3, 1); p_rw[1] = 1'b0; p_wdata[1] = 1'b1;
    p_addr[6] = mk_addr(2, 4, 6); p_rw[6] = 1'b1;
    run_txn(8'h42, -1, "rr_pair");
    run_txn(8'h42, -1, "rr_pair");
    for (int i = 0; i < 8; i++) begin
      p_addr[i]  = mk_addr($urandom_range(0, 7), $urandom_range(0, 2), $urandom_range(0, 7));
      p_rw[i]    = 1'($urandom_range(0, 1));
      p_wdata[i] = 1'($urandom_range(0, 1));
    end
    for (int t = 0; t < 9; t++) run_txn(8'hFF, -1, "rr_all");
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    model_clear();
    p_addr[3] = mk_addr(5, 9, 1); p_rw[3] = 1'b1;
    run_txn(8'h08, 2, "abort_wait_rcd");
    run_txn(8'h08, -1, "after_abort");
  endtask

  task automatic test_bank_independence();
    p_addr[0] = mk_addr(0, 1, 3); p_rw[0] = 1'b0; p_wdata[0] = 1'b1;
    p_addr[5] = mk_addr(1, 2, 4); p_rw[5] = 1'b1;
    p_addr[7] = mk_addr(0, 1, 5); p_rw[7] = 1'b1;
    run_txn(8'h01, -1, "bank0_open");
    run_txn(8'h20, -1, "bank1_open");
    run_txn(8'h80, -1, "bank0_hit");
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 8; i++) begin
        p_addr[i]  = mk_addr($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 7));
        p_rw[i]    = 1'($urandom_range(0, 1));
        p_wdata[i] = 1'($urandom_range(0, 1));
      end
      run_txn(8'($urandom_range(1, 255)), -1, "random");
    end
  endtask

  initial begin
    ifc.req_valid = '0;
    ifc.req_addr  = '0;
    ifc.req_rw    = '0;
    ifc.req_wdata = '0;
    test_reset();
    test_directed();
    test_round_robin();
    test_reset_mid();
    test_bank_independence();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dram_cmd_scheduler.md
Name: dram_cmd_scheduler

Overview:
Sequences the DRAM array for the eight L2 requester ports. Each cycle it can accept one request by round-robin arbitration, and it tracks the open row of every bank. It issues PRECHARGE/ACTIVATE/READ-WRITE commands with programmable timing and returns read data to the requester that made the request. It sits between the L2 request buffers and the bank/row/column decoders, with one request outstanding at a time.

Parameters:
NUM_REQ, 8, number of requester ports
L2_REQ_WIDTH, 22, request word: [21:19] bank, [18:12] row, [11:9] col, [8:0] offset (ignored)
DATA_WIDTH, 1, data width
NUM_OF_BANKS, 8, banks (bank id 3 bits)
NUM_OF_ROWS, 128, rows per bank (row id 7 bits)
NUM_OF_COLS, 8, columns (col id 3 bits)
T_RP, 2, cycles from the PRE cycle to the ACT cycle (range 1..15)
T_RCD, 2, cycles from the ACT cycle to the RW cycle (range 1..15)
T_CL, 2, cycles from the RD cycle to the data-sample cycle (range 1..15)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-port request valid
req_addr  in  NUM_REQ*L2_REQ_WIDTH  flattened; port i at [i*22 +: 22]
req_rw  in  NUM_REQ  1 = read, 0 = write
req_wdata  in  NUM_REQ*DATA_WIDTH  write data, flattened
req_ready  out  NUM_REQ  one-hot grant; request accepted when valid & ready
dram_data_in  in  DATA_WIDTH  read data from the array
cmd  out  2  00 NOP, 01 ACT, 10 RW, 11 PRE
cs  out  3  target bank
row_addr  out  7  row for ACT
col_addr  out  3  column for RW
dram_rw  out  1  read/write qualifier for a RW command
dram_data_out  out  DATA_WIDTH  write data, valid during a write RW cycle
rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse
rsp_data  out  DATA_WIDTH  read data, valid with rsp_valid

Behaviour:
- Reset (async, rst = 1):
  - State goes to IDLE; rr_ptr = 0.
  - All bank_open bits = 0; open_row table = 0.
  - Latched request registers are cleared.
  - Outputs: cmd = 00, cs = 0, row_addr = 0, col_addr = 0, dram_rw = 0, dram_data_out = 0, rsp_valid = 0, rsp_data = 0.
  - req_ready is forced to 0 while rst = 1.
- States: IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, RW, WAIT_CL, RESP.
- IDLE:
  - req_ready is combinational: a one-hot grant to the first valid port found searching from rr_ptr upward, modulo NUM_REQ.
  - On the grant: latch addr, rw, wdata and the port id; rr_ptr <= grant id + 1 (wraps 7 -> 0).
  - Next state:
    - bank open and row hit -> RW
    - bank open and row miss -> PRE
    - bank closed -> ACT
  - With no valid request, stay in IDLE with cmd = NOP.
- PRE (1 cycle): cmd = 11, cs = bank. Clear bank_open[bank]. Go to WAIT_RP loaded with T_RP-1; when T_RP = 1, go straight to ACT.
- ACT (1 cycle): cmd = 01, cs = bank, row_addr = row. Set bank_open[bank] = 1 and open_row[bank] = row. Go to WAIT_RCD with T_RCD-1 (straight to RW if T_RCD = 1).
- WAIT_*: cmd = NOP; decrement a 4-bit counter and exit when it reaches 0.
  - The ACT cycle falls exactly T_RP cycles after PRE.
  - The RW cycle falls exactly T_RCD cycles after ACT.
- RW (1 cycle): cmd = 10, cs, col_addr, dram_rw = latched rw.
  - Write: dram_data_out = latched wdata; go to RESP.
  - Read: go to WAIT_CL with T_CL-1.
- Read data capture: dram_data_in is sampled at the end of the cycle exactly T_CL cycles after RW and registered into rsp_data. Control then goes to RESP.
- RESP (1 cycle): rsp_valid[id] = 1. For writes rsp_data = 0. Return to IDLE. The next grant can occur in the following cycle.
- Open-page policy: rows stay open after access; no auto-precharge; no refresh.
- Row-table state for other banks is never disturbed by an access.
- Only the outputs listed for a state carry meaning; all others are held at 0 in every cycle other than that state.
- Reset asserted mid-operation aborts the transaction silently: no rsp_valid, row table cleared.

Decomposition:
- Package dram_ctrl_pkg holds:
  - cmd encodings (CMD_NOP/ACT/RW/PRE)
  - the FSM state enum
  - field offsets and widths for bank/row/col within the request word
  - the counter width
- Sub-module dram_rr_arbiter (NUM_REQ): inputs req vector, rr_ptr and enable; output one-hot grant plus encoded id; purely combinational.

Test Plan:
1. Reset, then req_valid[0] with addr 0x185400 (bank 3, row 5, col 2), read, at cycle 0 -> ready[0] @0, ACT cs=3 row=5 @1, RW col=2 dram_rw=1 @3, dram_data_in=1 held @5, rsp_valid=0x01 rsp_data=1 @6.
2. Row hit: after scenario 1, port 2 writes addr 0x185E00 (col 7), wdata 1 -> grant @g, RW @g+1 with dram_rw=0 dram_data_out=1, no ACT/PRE, rsp_valid=0x04 @g+2.
3. Row miss: port 4 reads bank 3 row 6 (0x186000) -> PRE cs=3 @g+1, ACT row=6 @g+3, RW @g+5, rsp @g+8.
4. Round-robin: all 8 valid continuously -> grant order 0,1,...,7,0. With rr_ptr=5 and only ports 1 and 6 valid -> port 6 granted first, then port 1.
5. Reset pulse during WAIT_RCD -> all outputs 0 immediately, no rsp_valid. A later read to the same bank/row issues ACT, not RW.
6. Bank independence: open bank 0 row 1, then bank 1 row 2, then access bank 0 row 1 again -> third access is a row hit (no PRE/ACT).
